// File: rtl/tape_pkg.sv
// Shared definitions for the tape block player.
// Holds the default timer widths, the FSM state encodings and the standard
// TZX block timings in ticks. No ports.
package tape_pkg;

    localparam int TW = 16;
    localparam int PW = 24;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PILOT = 3'd1;
    localparam logic [2:0] S_SYNC1 = 3'd2;
    localparam logic [2:0] S_SYNC2 = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;

    localparam logic [15:0] PILOT_T      = 16'd2168;
    localparam logic [15:0] PILOT_N_HDR  = 16'd8063;
    localparam logic [15:0] PILOT_N_DATA = 16'd3223;
    localparam logic [15:0] SYNC1_T      = 16'd667;
    localparam logic [15:0] SYNC2_T      = 16'd735;
    localparam logic [15:0] ZERO_T       = 16'd855;
    localparam logic [15:0] ONE_T        = 16'd1710;

endpackage

// File: rtl/tape_pulse_timer.sv
// Pulse/pause timer for the tape block player.
// Loads a length, counts it down on qualified ticks and strobes expired on
// the tick that takes the count from 1 to 0. A new length may be loaded on
// the same clk as the strobe, so back-to-back pulses lose no tick.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   tk            qualified tick (ce_tick & motor)
//   load, len     load a new length; 0 is treated as 1
//   expired       one-clk strobe on the final tick of the loaded length
module tape_pulse_timer
    import tape_pkg::*;
#(
    parameter int W = PW
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tk,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expired
);

    logic [W-1:0] cnt;

    assign expired = tk && (cnt == W'(1));

    // Load wins over a coincident tick: that tick closed the previous pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? W'(1) : len;
        end else if (tk && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/tape_block_player.sv
// CPC tape block transmitter: plays pilot tone, two sync pulses, the data
// bytes MSB-first as two-pulse bits, then a trailing pause at level 0.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   ce_tick, motor     tick enable and motor gate; timing only on both
//   start              begins a block from IDLE (ignored on the done clk)
//   pilot_t..pause_t   block timings, sampled on the accepted start
//   din, din_valid, din_last, din_ready   byte stream in
//   tape_level         level towards the motherboard tape input
//   busy, done, underrun  status
//
// state   | meaning
// IDLE    | waiting for start
// PILOT   | pilot pulses, pcnt counts the remaining ones
// SYNC1   | first sync pulse
// SYNC2   | second sync pulse; its edge fetches the first byte
// DATA    | bit pulses from sr; waiting=1 while a fetch is stalled
// PAUSE   | level held at 0 for pause_t ticks
module tape_block_player #(
    parameter int TW = tape_pkg::TW,
    parameter int PW = tape_pkg::PW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_tick,
    input  logic          motor,
    input  logic          start,
    input  logic [TW-1:0] pilot_t,
    input  logic [15:0]   pilot_n,
    input  logic [TW-1:0] sync1_t,
    input  logic [TW-1:0] sync2_t,
    input  logic [TW-1:0] zero_t,
    input  logic [TW-1:0] one_t,
    input  logic [PW-1:0] pause_t,
    input  logic [7:0]    din,
    input  logic          din_valid,
    input  logic          din_last,
    output logic          din_ready,
    output logic          tape_level,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    import tape_pkg::*;

    logic [2:0]    state, state_n;
    logic [TW-1:0] pilot_r, sync1_r, sync2_r, zero_r, one_r;
    logic [PW-1:0] pause_r;
    logic [15:0]   pcnt, pcnt_n;
    logic [7:0]    sr, sr_n;
    logic [2:0]    bc, bc_n;
    logic          h, h_n;
    logic          last_f, last_n;
    logic          waiting, waiting_n;
    logic          level_n, underrun_n, done_n;
    logic          tk, expired, accept, fetch;
    logic          t_load;
    logic [PW-1:0] t_len;
    logic [PW-1:0] len_cur, len_nxt, len_in;

    assign tk     = ce_tick & motor;
    assign accept = start && (state == S_IDLE) && !done;
    assign busy   = (state != S_IDLE);

    // A fetch happens on the edge that ends SYNC2 or the last pulse of a
    // non-final byte, so a ready byte keeps edges exactly one length apart;
    // if no byte is there it keeps repeating from the waiting flag.
    assign fetch = ((state == S_SYNC2) && expired) ||
                   ((state == S_DATA) &&
                    (waiting || (expired && h && (bc == 3'd0) && !last_f)));
    assign din_ready = fetch;

    assign len_cur = PW'(sr[7]  ? one_r : zero_r);
    assign len_nxt = PW'(sr[6]  ? one_r : zero_r);
    assign len_in  = PW'(din[7] ? one_r : zero_r);

    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        sr_n       = sr;
        bc_n       = bc;
        h_n        = h;
        last_n     = last_f;
        waiting_n  = waiting;
        level_n    = tape_level;
        underrun_n = underrun;
        done_n     = 1'b0;
        t_load     = 1'b0;
        t_len      = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    underrun_n = 1'b0;
                    pcnt_n     = pilot_n;
                    t_load     = 1'b1;
                    if (pilot_n != 16'd0) begin
                        state_n = S_PILOT;
                        t_len   = PW'(pilot_t);
                    end else begin
                        state_n = S_SYNC1;
                        t_len   = PW'(sync1_t);
                    end
                end
            end
            S_PILOT: begin
                if (expired) begin
                    level_n = ~tape_level;
                    t_load  = 1'b1;
                    if (pcnt == 16'd1) begin
                        state_n = S_SYNC1;
                        pcnt_n  = '0;
                        t_len   = PW'(sync1_r);
                    end else begin
                        pcnt_n = pcnt - 16'd1;
                        t_len  = PW'(pilot_r);
                    end
                end
            end
            S_SYNC1: begin
                if (expired) begin
                    level_n = ~tape_level;
                    state_n = S_SYNC2;
                    t_load  = 1'b1;
                    t_len   = PW'(sync2_r);
                end
            end
            S_SYNC2: begin
                if (expired) begin
                    level_n = ~tape_level;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (expired) begin
                    level_n = ~tape_level;
                    if (!h) begin
                        h_n    = 1'b1;
                        t_load = 1'b1;
                        t_len  = len_cur;
                    end else if (bc != 3'd0) begin
                        h_n    = 1'b0;
                        bc_n   = bc - 3'd1;
                        sr_n   = {sr[6:0], 1'b0};
                        t_load = 1'b1;
                        t_len  = len_nxt;
                    end else if (last_f) begin
                        state_n = S_PAUSE;
                        level_n = 1'b0;
                        t_load  = 1'b1;
                        t_len   = pause_r;
                    end
                end
            end
            S_PAUSE: begin
                // A zero pause still waits for the motor so a stopped deck
                // never completes a block.
                if ((pause_r == '0) ? motor : expired) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (fetch) begin
            if (din_valid) begin
                sr_n      = din;
                last_n    = din_last;
                bc_n      = 3'd7;
                h_n       = 1'b0;
                waiting_n = 1'b0;
                t_load    = 1'b1;
                t_len     = len_in;
            end else begin
                waiting_n  = 1'b1;
                underrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pcnt       <= '0;
            sr         <= '0;
            bc         <= '0;
            h          <= 1'b0;
            last_f     <= 1'b0;
            waiting    <= 1'b0;
            tape_level <= 1'b0;
            underrun   <= 1'b0;
            done       <= 1'b0;
            pilot_r    <= '0;
            sync1_r    <= '0;
            sync2_r    <= '0;
            zero_r     <= '0;
            one_r      <= '0;
            pause_r    <= '0;
        end else begin
            state      <= state_n;
            pcnt       <= pcnt_n;
            sr         <= sr_n;
            bc         <= bc_n;
            h          <= h_n;
            last_f     <= last_n;
            waiting    <= waiting_n;
            tape_level <= level_n;
            underrun   <= underrun_n;
            done       <= done_n;
            if (accept) begin
                pilot_r <= pilot_t;
                sync1_r <= sync1_t;
                sync2_r <= sync2_t;
                zero_r  <= zero_t;
                one_r   <= one_t;
                pause_r <= pause_t;
            end
        end
    end

    tape_pulse_timer #(.W(PW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tk      (tk),
        .load    (t_load),
        .len     (t_len),
        .expired (expired)
    );

endmodule

// File: tb/tb_tape_block_player.sv
module tb_tape_block_player;
    import tape_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ce_tick = 1'b0;
    logic          motor = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   pilot_t = '0;
    logic [15:0]   pilot_n = '0;
    logic [15:0]   sync1_t = '0;
    logic [15:0]   sync2_t = '0;
    logic [15:0]   zero_t = '0;
    logic [15:0]   one_t = '0;
    logic [23:0]   pause_t = '0;
    logic [7:0]    din = '0;
    logic          din_valid = 1'b0;
    logic          din_last = 1'b0;
    logic          din_ready, tape_level, busy, done, underrun;

    int checks = 0;
    int errors = 0;

    int         exp_q[$];
    int         pause_q[$];
    logic [8:0] feed_q[$];
    logic [7:0] blk_bytes[$];

    int   ce_period = 4;
    logic ce_en = 1'b0;
    int   phase = 0;
    logic xfer_pending = 1'b0;

    int   ticks = 0, cyc = 0, mon_ref = 0, blk_ref = 0;
    int   edge_cyc = 0, edge_cnt = 0, done_cnt = 0, done_total = 0;
    logic mon_prev = 1'b0;

    tape_block_player dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_tick    (ce_tick),
        .motor      (motor),
        .start      (start),
        .pilot_t    (pilot_t),
        .pilot_n    (pilot_n),
        .sync1_t    (sync1_t),
        .sync2_t    (sync2_t),
        .zero_t     (zero_t),
        .one_t      (one_t),
        .pause_t    (pause_t),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .tape_level (tape_level),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the byte at the head of feed_q is
    // offered until the DUT takes it.
    always @(negedge clk) begin
        if (ce_en) begin
            ce_tick = (phase == 0);
            phase = (phase + 1) % ce_period;
        end else begin
            ce_tick = 1'b0;
        end
        if (feed_q.size() != 0) begin
            din       = feed_q[0][7:0];
            din_last  = feed_q[0][8];
            din_valid = 1'b1;
        end else begin
            din       = '0;
            din_last  = 1'b0;
            din_valid = 1'b0;
        end
        #1;
        xfer_pending = din_valid && din_ready;
        if (xfer_pending) void'(feed_q.pop_front());
    end

    // Scoreboard: measures qualified ticks between level edges and from the
    // last edge to done, against the queued expectations.
    always @(posedge clk) begin
        logic xp;
        int   iv, ex, p;
        cyc++;
        if (ce_tick && motor) ticks++;
        xp = xfer_pending;
        #1;
        if (reset_n && (tape_level !== mon_prev)) begin
            iv       = ticks - mon_ref;
            mon_ref  = ticks;
            mon_prev = tape_level;
            edge_cyc = cyc;
            edge_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_edge: edge after %0d ticks, required no edge", iv);
            end else begin
                ex = exp_q.pop_front();
                if (iv != ex) begin
                    errors++;
                    $display("FAIL edge_interval: edge %0d after %0d ticks, required %0d", edge_cnt, iv, ex);
                end
            end
        end
        if (xp) mon_ref = ticks;
        if (reset_n && (done === 1'b1)) begin
            done_cnt++;
            done_total = ticks - blk_ref;
            checks++;
            if (pause_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1, required 0");
            end else begin
                p = pause_q.pop_front();
                if (p > 0) begin
                    if (ticks - mon_ref != p) begin
                        errors++;
                        $display("FAIL pause_ticks: %0d ticks, required %0d", ticks - mon_ref, p);
                    end
                end else if (cyc - edge_cyc != 1) begin
                    errors++;
                    $display("FAIL pause_zero_delay: done %0d clk after edge, required 1", cyc - edge_cyc);
                end
            end
            checks++;
            if (busy !== 1'b0 || tape_level !== 1'b0) begin
                errors++;
                $display("FAIL done_state: busy=%b level=%b, required 0 0", busy, tape_level);
            end
        end
    end

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic set_timing(input int pt, input int pn, input int s1, input int s2,
                              input int z, input int o, input int pa);
        pilot_t = 16'(pt);
        pilot_n = 16'(pn);
        sync1_t = 16'(s1);
        sync2_t = 16'(s2);
        zero_t  = 16'(z);
        one_t   = 16'(o);
        pause_t = 24'(pa);
    endtask

    task automatic push_expect(input int n_feed, output int total);
        int l;
        total = 0;
        for (int i = 0; i < int'(pilot_n); i++) begin
            exp_q.push_back(eff(int'(pilot_t)));
            total += eff(int'(pilot_t));
        end
        exp_q.push_back(eff(int'(sync1_t)));
        exp_q.push_back(eff(int'(sync2_t)));
        total += eff(int'(sync1_t)) + eff(int'(sync2_t));
        for (int b = 0; b < blk_bytes.size(); b++) begin
            for (int k = 7; k >= 0; k--) begin
                l = blk_bytes[b][k] ? eff(int'(one_t)) : eff(int'(zero_t));
                exp_q.push_back(l);
                exp_q.push_back(l);
                total += 2 * l;
            end
        end
        pause_q.push_back(int'(pause_t));
        total += int'(pause_t);
        for (int b = 0; b < n_feed; b++)
            feed_q.push_back({(b == blk_bytes.size() - 1) ? 1'b1 : 1'b0, blk_bytes[b]});
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        mon_ref = ticks;
        blk_ref = ticks;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d clk, required done", name, limit);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_edges: %0d edges missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_edges(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (edge_cnt < target && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (edge_cnt < target) begin
            errors++;
            $display("FAIL %s_edge_timeout: %0d edges, required %0d", name, edge_cnt, target);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tape_level !== 1'b0) begin errors++; $display("FAIL reset_level: %b, required 0", tape_level); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", done); end
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b, required 0", din_ready); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: %b, required 0", underrun); end
        @(negedge clk);
        reset_n = 1'b1;
        motor   = 1'b1;
        ce_en   = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_standard_block();
        int total;
        ce_period = 1;
        set_timing(int'(PILOT_T), 4, int'(SYNC1_T), int'(SYNC2_T), int'(ZERO_T), int'(ONE_T), 3500);
        blk_bytes = '{8'hA5, 8'h3C};
        push_expect(2, total);
        do_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL std_busy: %b, required 1", busy); end
        // timing inputs move mid-block; the sampled copies must be used
        set_timing(7, 1, 3, 3, 2, 5, 9);
        repeat (3000) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(70000, "std");
        checks++;
        if (done_total != total) begin
            errors++;
            $display("FAIL std_total: %0d ticks, required %0d", done_total, total);
        end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL std_underrun: %b, required 0", underrun); end
    endtask

    task automatic test_underrun();
        int   total, n, bad, e0;
        logic lvl;
        ce_period = 4;
        set_timing(20, 2, 7, 9, 5, 10, 30);
        blk_bytes = '{8'hA5, 8'h3C};
        push_expect(1, total);
        do_start();
        n = 0;
        while (underrun !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: %b, required 1", underrun); end
        lvl = tape_level;
        e0  = edge_cnt;
        bad = 0;
        repeat (100) begin
            @(posedge clk);
            #2;
            if (tape_level !== lvl || din_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || edge_cnt != e0) begin
            errors++;
            $display("FAIL underrun_hold: %0d bad clk, %0d edges, required 0 0", bad, edge_cnt - e0);
        end
        feed_q.push_back({1'b1, 8'h3C});
        wait_done(5000, "underrun");
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: %b, required 1", underrun); end
    endtask

    task automatic test_motor_gating();
        int   total, e0;
        logic lvl;
        ce_period = 4;
        set_timing(50, 6, 11, 13, 6, 12, 20);
        blk_bytes = '{8'h81};
        push_expect(1, total);
        e0 = edge_cnt;
        do_start();
        wait_edges(e0 + 2, 2000, "motor");
        repeat (20) @(posedge clk);
        @(negedge clk);
        motor = 1'b0;
        lvl = tape_level;
        e0  = edge_cnt;
        repeat (500) @(posedge clk);
        #2;
        checks++;
        if (edge_cnt != e0 || tape_level !== lvl) begin
            errors++;
            $display("FAIL motor_gap: %0d edges level=%b, required 0 edges level=%b", edge_cnt - e0, tape_level, lvl);
        end
        @(negedge clk);
        motor = 1'b1;
        wait_done(6000, "motor");
    endtask

    task automatic test_zero_corners();
        int total;
        ce_period = 4;
        set_timing(9, 0, 4, 5, 0, 3, 0);
        blk_bytes = '{8'h0F};
        push_expect(1, total);
        do_start();
        wait_done(1000, "zero");
    endtask

    task automatic test_async_reset();
        int total, e0;
        ce_period = 4;
        set_timing(8, 4, 5, 6, 4, 7, 10);
        blk_bytes = '{8'hC3, 8'h5A};
        push_expect(2, total);
        e0 = edge_cnt;
        do_start();
        wait_edges(e0 + 7, 2000, "areset");
        reset_n  = 1'b0;
        mon_prev = 1'b0;
        #1;
        checks++;
        if (tape_level !== 1'b0) begin errors++; $display("FAIL areset_level: %b, required 0", tape_level); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: %b, required 0", busy); end
        checks++;
        if (din_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: %b, required 0", din_ready); end
        exp_q.delete();
        pause_q.delete();
        feed_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        push_expect(2, total);
        do_start();
        wait_done(3000, "restart");
    endtask

    task automatic test_start_done();
        int total, n, e0;
        ce_period = 4;
        set_timing(6, 2, 3, 4, 2, 5, 8);
        blk_bytes = '{8'h96};
        push_expect(1, total);
        do_start();
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sd_done_seen: %b, required 1", done); end
        start = 1'b1;
        e0 = edge_cnt;
        @(posedge clk);
        #2;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sd_busy: %b, required 0", busy); end
        repeat (60) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || edge_cnt != e0) begin
            errors++;
            $display("FAIL sd_idle: busy=%b %0d edges, required 0 0", busy, edge_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_standard_block();
        test_underrun();
        test_motor_gating();
        test_zero_corners();
        test_async_reset();
        test_start_done();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
